stack_seq_ctrl: RTL
===================

Name: stack_seq_ctrl

Overview:
- Memory-stage controller that sequences multi-word stack transfers: CALL, INT, RET, RTI, plus single-word PUSH/POP.
- Drives the pc_to_stack/pc_segment select of the memory-stage write-data mux.
- Drives data-memory read/write strobes and address, and owns the stack pointer.
- Stalls the pipeline until the sequence completes.

Parameters:
- ADDR_W, 12, data-memory word-address width (SP width).
- SP_INIT, {ADDR_W{1'b1}}, SP value after reset (stack grows downward).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- call_req  in  1  push PC_H, PC_L
- int_req  in  1  push PC_H, PC_L, FLAGS
- ret_req  in  1  pop PC_L, PC_H
- rti_req  in  1  pop FLAGS, PC_L, PC_H
- push_req  in  1  push ALU data word
- pop_req  in  1  pop one word to register file
- pc_to_stack  out  1  mux select: 1 = PC/flags, 0 = ALU data
- pc_segment  out  2  00 = PC_H, 01 = PC_L, 10 = FLAGS
- mem_wr  out  1  data-memory write strobe
- mem_rd  out  1  data-memory read strobe (synchronous RAM, data valid next cycle)
- mem_addr  out  ADDR_W  memory address
- sp  out  ADDR_W  current stack pointer
- stall  out  1  freeze upstream pipeline
- ld_pc_h, ld_pc_l, ld_flags, ld_reg  out  1 each  capture-enable pulses, aligned with valid read data
- seq_done  out  1  one-cycle pulse in the final cycle of a sequence

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, sp=SP_INIT. All strobes, ld_*, stall, seq_done, pc_to_stack = 0; pc_segment=00. Reset mid-sequence aborts immediately; no further memory access occurs.
- Request sampling: requests are sampled only in IDLE. Priority is int > rti > ret > call > pop > push; lower-priority requests in the same cycle are ignored. Requests arriving outside IDLE are ignored.
- IDLE: no strobes; mem_addr=sp. stall=1 combinationally if any request is high. The next state is the first state of the selected sequence.
- Push state: mem_wr=1, mem_addr=sp, sp<=sp-1 at the clock edge.
  - PUSH_H: pc_to_stack=1, seg=00
  - PUSH_L: pc_to_stack=1, seg=01
  - PUSH_F: pc_to_stack=1, seg=10
  - PUSH_R: pc_to_stack=0
- Pop state: mem_rd=1, mem_addr=sp+1, sp<=sp+1. The matching ld_* pulses in the following cycle.
  - POP_F -> ld_flags
  - POP_L -> ld_pc_l
  - POP_H -> ld_pc_h
  - POP_R -> ld_reg
- POP_WAIT: no strobes; only the pending ld_* pulse fires.
- Sequences and cycle counts:
  - CALL: PUSH_H, PUSH_L (2 cycles)
  - INT: PUSH_H, PUSH_L, PUSH_F (3 cycles)
  - PUSH: PUSH_R (1 cycle)
  - RET: POP_L, POP_H, POP_WAIT (3 cycles)
  - RTI: POP_F, POP_L, POP_H, POP_WAIT (4 cycles)
  - POP: POP_R, POP_WAIT (2 cycles)
- Final state of every sequence: seq_done=1, stall=0, next state IDLE. The pipeline advances on that edge, so a held request is not re-triggered. In all other non-IDLE states, stall=1.
- Back-to-back: a new request present in IDLE on the cycle after seq_done starts immediately, with no idle bubble beyond that one IDLE cycle.
- SP arithmetic is modulo 2^ADDR_W; wrap is silent, with no overflow/underflow flag.
- pc_segment=11 is never driven.

Decomposition:
- Shared package stack_pkg holds:
  - state enum: IDLE, PUSH_H, PUSH_L, PUSH_F, PUSH_R, POP_F, POP_L, POP_H, POP_R, POP_WAIT
  - segment constants: SEG_PC_H=2'b00, SEG_PC_L=2'b01, SEG_FLAGS=2'b10
- Single module, no sub-module. The SP register and its +/-1 adder stay inline.

Test Plan:
- CALL from reset (sp=FFF): two writes, at FFF seg 00 then FFE seg 01, pc_to_stack=1 on both. stall=1,1,0 over request/PUSH_H/PUSH_L. seq_done on the second write; sp=FFD.
- INT then RTI: writes at FFF/FFE/FFD with segs 00/01/10, sp=FFC. Then reads at FFD, FFE, FFF; ld_flags, ld_pc_l, ld_pc_h pulse in cycles 2, 3, 4 of RTI. sp=FFF; seq_done in cycle 4.
- Simultaneous int_req+call_req+push_req: only the INT sequence runs (3 writes), sp decreases by exactly 3.
- PUSH with SP_INIT=000: write at addr 000 with pc_to_stack=0, sp wraps to FFF. Then POP: read at 000, ld_reg next cycle, sp=000.
- Reset asserted after PUSH_H of an INT: outputs zero asynchronously, sp=FFF, no further mem_wr. After release, the controller is idle.
- Held call_req across seq_done, then a ret_req one cycle later: exactly one CALL sequence, then RET reads back at sp+1 and sp+2 in order.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types for the memory-stage stack sequencer.
// State encoding and write-data mux segment codes.
package stack_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PUSH_H,
        PUSH_L,
        PUSH_F,
        PUSH_R,
        POP_F,
        POP_L,
        POP_H,
        POP_R,
        POP_WAIT
    } state_t;

    localparam logic [1:0] SEG_PC_H  = 2'b00;
    localparam logic [1:0] SEG_PC_L  = 2'b01;
    localparam logic [1:0] SEG_FLAGS = 2'b10;

    // Index of each capture pulse inside the pending-load vector
    localparam int LD_R = 0;
    localparam int LD_F = 1;
    localparam int LD_L = 2;
    localparam int LD_H = 3;

endpackage

// File: rtl/stack_seq_ctrl.sv
// Memory-stage stack transfer sequencer: CALL/INT/RET/RTI/PUSH/POP.
// Owns the stack pointer and stalls the pipeline until a sequence ends.
module stack_seq_ctrl
    import stack_pkg::*;
#(
    parameter int                ADDR_W  = 12,
    parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              call_req,
    input  logic              int_req,
    input  logic              ret_req,
    input  logic              rti_req,
    input  logic              push_req,
    input  logic              pop_req,
    output logic              pc_to_stack,
    output logic [1:0]        pc_segment,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] sp,
    output logic              stall,
    output logic              ld_pc_h,
    output logic              ld_pc_l,
    output logic              ld_flags,
    output logic              ld_reg,
    output logic              seq_done
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_sp;
    logic              r_is_int;
    logic [3:0]        r_ld;

    state_t            w_nxt;
    logic              w_is_int_nxt;
    logic [3:0]        w_ld_nxt;
    logic [ADDR_W-1:0] w_sp_nxt;
    logic [ADDR_W-1:0] w_sp_inc;
    logic [ADDR_W-1:0] w_sp_dec;
    logic              w_any_req;
    logic              w_wr;
    logic              w_rd;
    logic              w_pcts;
    logic [1:0]        w_seg;
    logic [ADDR_W-1:0] w_addr;
    logic              w_stall;
    logic              w_done;

    assign w_sp_inc  = r_sp + 1'b1;
    assign w_sp_dec  = r_sp - 1'b1;
    assign w_any_req = call_req | int_req | ret_req |
                       rti_req | push_req | pop_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_sp     <= SP_INIT;
            r_is_int <= 1'b0;
            r_ld     <= 4'b0;
        end else begin
            r_state  <= w_nxt;
            r_sp     <= w_sp_nxt;
            r_is_int <= w_is_int_nxt;
            r_ld     <= w_ld_nxt;
        end
    end

    always_comb begin
        w_nxt        = r_state;
        w_is_int_nxt = r_is_int;
        w_ld_nxt     = 4'b0;
        w_sp_nxt     = r_sp;
        w_wr         = 1'b0;
        w_rd         = 1'b0;
        w_pcts       = 1'b0;
        w_seg        = SEG_PC_H;
        w_addr       = r_sp;
        w_stall      = 1'b1;
        w_done       = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_stall = w_any_req;
                if (int_req) begin
                    w_nxt        = PUSH_H;
                    w_is_int_nxt = 1'b1;
                end else if (rti_req) begin
                    w_nxt = POP_F;
                end else if (ret_req) begin
                    w_nxt = POP_L;
                end else if (call_req) begin
                    w_nxt        = PUSH_H;
                    w_is_int_nxt = 1'b0;
                end else if (pop_req) begin
                    w_nxt = POP_R;
                end else if (push_req) begin
                    w_nxt = PUSH_R;
                end
            end
            PUSH_H, PUSH_L, PUSH_F, PUSH_R: begin
                w_wr     = 1'b1;
                w_sp_nxt = w_sp_dec;
                w_pcts   = (r_state != PUSH_R);
                if (r_state == PUSH_L) w_seg = SEG_PC_L;
                if (r_state == PUSH_F) w_seg = SEG_FLAGS;
                // CALL ends after PC_L, INT goes on to push the flags
                if (r_state == PUSH_H) begin
                    w_nxt = PUSH_L;
                end else if (r_state == PUSH_L && r_is_int) begin
                    w_nxt = PUSH_F;
                end else begin
                    w_nxt   = IDLE;
                    w_stall = 1'b0;
                    w_done  = 1'b1;
                end
            end
            POP_F, POP_L, POP_H, POP_R: begin
                w_rd     = 1'b1;
                w_addr   = w_sp_inc;
                w_sp_nxt = w_sp_inc;
                unique case (r_state)
                    POP_F: begin
                        w_nxt          = POP_L;
                        w_ld_nxt[LD_F] = 1'b1;
                    end
                    POP_L: begin
                        w_nxt          = POP_H;
                        w_ld_nxt[LD_L] = 1'b1;
                    end
                    POP_H: begin
                        w_nxt          = POP_WAIT;
                        w_ld_nxt[LD_H] = 1'b1;
                    end
                    default: begin
                        w_nxt          = POP_WAIT;
                        w_ld_nxt[LD_R] = 1'b1;
                    end
                endcase
            end
            POP_WAIT: begin
                w_nxt   = IDLE;
                w_stall = 1'b0;
                w_done  = 1'b1;
            end
            default: begin
                w_nxt   = IDLE;
                w_stall = 1'b0;
            end
        endcase
    end

    assign pc_to_stack = w_pcts;
    assign pc_segment  = w_seg;
    assign mem_wr      = w_wr;
    assign mem_rd      = w_rd;
    assign mem_addr    = w_addr;
    assign sp          = r_sp;
    // Requests may be high while reset is held; keep stall quiet then
    assign stall       = w_stall & rst;
    assign seq_done    = w_done;
    assign ld_reg      = r_ld[LD_R];
    assign ld_flags    = r_ld[LD_F];
    assign ld_pc_l     = r_ld[LD_L];
    assign ld_pc_h     = r_ld[LD_H];

endmodule
